blade_renderer_pipe: RTL and testbench

//  Parametrised, pipelined lightsaber blade renderer for the VGA pixel path.

---
 rtl/blade_renderer_pipe.sv | 219 +++++++++++++++++++++
 tb/tb_blade_renderer_pipe.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/blade_renderer_pipe.sv
// Lightsaber blade renderer: once per frame a setup FSM turns the handle endpoints into a blade segment.
// A 4-stage pixel pipeline then tests each pixel against that segment (square ends, depth-scaled width).
module blade_renderer_pipe #(
    parameter logic [23:0] COLOR       = 24'hFF_FF_FF,
    parameter int          LENGTH_MULT = 1,
    parameter int          HALF_WIDTH  = 6,
    parameter int          Z_SHIFT     = 6,
    parameter int          IGN_STEP    = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic        enable,
    input  logic [10:0] handle_top_x,
    input  logic [9:0]  handle_top_y,
    input  logic [10:0] handle_top_z,
    input  logic [10:0] handle_bottom_x,
    input  logic [9:0]  handle_bottom_y,
    input  logic [10:0] handle_bottom_z,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    output logic [23:0] pixel,
    output logic        occupied,
    output logic        setup_busy
);

    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_EXT, S_LEN, S_PUB} state_t;

    localparam logic signed [31:0] LMULT_S = 32'(LENGTH_MULT);
    localparam logic signed [12:0] HW_S    = 13'(HALF_WIDTH);
    localparam logic [5:0]         STEP_U  = 6'(IGN_STEP);

    state_t state_q, state_d;

    // Handle endpoints captured once per frame
    logic [10:0] sh_top_x_q, sh_bot_x_q, sh_top_z_q, sh_bot_z_q;
    logic [9:0]  sh_top_y_q, sh_bot_y_q;
    logic [4:0]  ign_q, ign_d;

    // Setup results, built up over S_EXT and S_LEN
    logic [10:0]        base_x_s_q;
    logic [9:0]         base_y_s_q;
    logic signed [11:0] vx_s_q, vy_s_q, vx_d, vy_d;
    logic [5:0]         hw_s_q, hw_d;
    logic [20:0]        len2_s_q, len2_d;
    logic [32:0]        hwlen_s_q, hwlen_d;

    // Active geometry seen by the pixel pipeline
    logic [10:0]        base_x_a_q;
    logic [9:0]         base_y_a_q;
    logic signed [11:0] vx_a_q, vy_a_q;
    logic [20:0]        len2_a_q;
    logic [32:0]        hwlen_a_q;

    function automatic logic signed [11:0] clamp_axis(input logic signed [31:0] v);
        logic signed [11:0] r;
        if (v > 32'sd1023) begin
            r = 12'sd1023;
        end else if (v < -32'sd1023) begin
            r = -12'sd1023;
        end else begin
            r = v[11:0];
        end
        return r;
    endfunction

    assign setup_busy = (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (frame_start) state_d = S_LATCH;
            S_LATCH: state_d = S_EXT;
            S_EXT:   state_d = S_LEN;
            S_LEN:   state_d = S_PUB;
            S_PUB:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    logic [5:0] ign_up;
    always_comb begin
        ign_up = {1'b0, ign_q} + STEP_U;
        ign_d  = ign_q;
        if (enable) begin
            ign_d = (ign_up > 6'd16) ? 5'd16 : ign_up[4:0];
        end else begin
            ign_d = ({1'b0, ign_q} < STEP_U) ? 5'd0 : ign_q - STEP_U[4:0];
        end
    end

    // Blade vector: handle vector scaled by LENGTH_MULT and ignition/16, floor shift
    logic signed [11:0] dx, dy;
    logic signed [31:0] dx_w, dy_w, ign_w, ext_x, ext_y;
    logic [11:0]        z_sum;
    logic [10:0]        z_red;
    logic signed [12:0] hw_full;
    always_comb begin
        dx      = $signed({1'b0, sh_top_x_q}) - $signed({1'b0, sh_bot_x_q});
        dy      = $signed({2'b0, sh_top_y_q}) - $signed({2'b0, sh_bot_y_q});
        dx_w    = 32'(dx);
        dy_w    = 32'(dy);
        ign_w   = $signed({27'd0, ign_q});
        ext_x   = (dx_w * LMULT_S * ign_w) >>> 4;
        ext_y   = (dy_w * LMULT_S * ign_w) >>> 4;
        vx_d    = clamp_axis(ext_x);
        vy_d    = clamp_axis(ext_y);
        z_sum   = {1'b0, sh_top_z_q} + {1'b0, sh_bot_z_q};
        z_red   = z_sum[11:1] >> Z_SHIFT;
        hw_full = HW_S - $signed({2'b0, z_red});
        hw_d    = (hw_full < 13'sd1) ? 6'd1 : hw_full[5:0];
    end

    logic signed [23:0] sq_x, sq_y;
    always_comb begin
        sq_x    = 24'(vx_s_q) * 24'(vx_s_q);
        sq_y    = 24'(vy_s_q) * 24'(vy_s_q);
        len2_d  = sq_x[20:0] + sq_y[20:0];
        hwlen_d = 33'(hw_s_q) * 33'(hw_s_q) * 33'(len2_d);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            sh_top_x_q <= '0;
            sh_top_y_q <= '0;
            sh_top_z_q <= '0;
            sh_bot_x_q <= '0;
            sh_bot_y_q <= '0;
            sh_bot_z_q <= '0;
            ign_q      <= '0;
            base_x_s_q <= '0;
            base_y_s_q <= '0;
            vx_s_q     <= '0;
            vy_s_q     <= '0;
            hw_s_q     <= '0;
            len2_s_q   <= '0;
            hwlen_s_q  <= '0;
            base_x_a_q <= '0;
            base_y_a_q <= '0;
            vx_a_q     <= '0;
            vy_a_q     <= '0;
            len2_a_q   <= '0;
            hwlen_a_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_LATCH) begin
                sh_top_x_q <= handle_top_x;
                sh_top_y_q <= handle_top_y;
                sh_top_z_q <= handle_top_z;
                sh_bot_x_q <= handle_bottom_x;
                sh_bot_y_q <= handle_bottom_y;
                sh_bot_z_q <= handle_bottom_z;
                ign_q      <= ign_d;
            end
            if (state_q == S_EXT) begin
                base_x_s_q <= sh_top_x_q;
                base_y_s_q <= sh_top_y_q;
                vx_s_q     <= vx_d;
                vy_s_q     <= vy_d;
                hw_s_q     <= hw_d;
            end
            if (state_q == S_LEN) begin
                len2_s_q  <= len2_d;
                hwlen_s_q <= hwlen_d;
            end
            // Single-cycle publish keeps the active geometry consistent within a frame
            if (state_q == S_PUB) begin
                base_x_a_q <= base_x_s_q;
                base_y_a_q <= base_y_s_q;
                vx_a_q     <= vx_s_q;
                vy_a_q     <= vy_s_q;
                len2_a_q   <= len2_s_q;
                hwlen_a_q  <= hwlen_s_q;
            end
        end
    end

    // Pixel pipeline
    logic signed [11:0] px_q, py_q, px_d, py_d;
    logic signed [23:0] cross_q, dot_q, dot3_q, cross_d, dot_d;
    logic signed [47:0] cross_sq;
    logic [47:0]        cross2_q;
    logic               in_blade;

    always_comb begin
        px_d     = $signed({1'b0, hcount}) - $signed({1'b0, base_x_a_q});
        py_d     = $signed({2'b0, vcount}) - $signed({2'b0, base_y_a_q});
        cross_d  = 24'(px_q) * 24'(vy_a_q) - 24'(py_q) * 24'(vx_a_q);
        dot_d    = 24'(px_q) * 24'(vx_a_q) + 24'(py_q) * 24'(vy_a_q);
        cross_sq = 48'(cross_q) * 48'(cross_q);
        in_blade = (len2_a_q != 21'd0) && !dot3_q[23]
                   && (dot3_q[22:0] <= {2'b0, len2_a_q})
                   && (cross2_q <= {15'd0, hwlen_a_q});
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            px_q     <= '0;
            py_q     <= '0;
            cross_q  <= '0;
            dot_q    <= '0;
            cross2_q <= '0;
            dot3_q   <= '0;
            occupied <= 1'b0;
            pixel    <= '0;
        end else begin
            px_q     <= px_d;
            py_q     <= py_d;
            cross_q  <= cross_d;
            dot_q    <= dot_d;
            cross2_q <= $unsigned(cross_sq);
            dot3_q   <= dot_q;
            occupied <= in_blade;
            pixel    <= in_blade ? COLOR : 24'd0;
        end
    end

endmodule

// File: tb/tb_blade_renderer_pipe.sv
// Scoreboard bench for blade_renderer_pipe: expected pixels are queued at issue time and checked
// 4 clocks later by an independent monitor.
module tb_blade_renderer_pipe;

    localparam logic [23:0] COLOR = 24'hFF_FF_FF;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        enable = 1'b0;
    logic [10:0] handle_top_x = '0, handle_top_z = '0, handle_bottom_x = '0, handle_bottom_z = '0;
    logic [9:0]  handle_top_y = '0, handle_bottom_y = '0;
    logic [10:0] hcount = 11'd1000;
    logic [9:0]  vcount = 10'd700;
    logic [23:0] pixel;
    logic        occupied;
    logic        setup_busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    blade_renderer_pipe #(
        .COLOR(COLOR), .LENGTH_MULT(1), .HALF_WIDTH(6), .Z_SHIFT(6), .IGN_STEP(2)
    ) dut (
        .clock(clock), .reset_n(reset_n), .frame_start(frame_start), .enable(enable),
        .handle_top_x(handle_top_x), .handle_top_y(handle_top_y), .handle_top_z(handle_top_z),
        .handle_bottom_x(handle_bottom_x), .handle_bottom_y(handle_bottom_y),
        .handle_bottom_z(handle_bottom_z),
        .hcount(hcount), .vcount(vcount),
        .pixel(pixel), .occupied(occupied), .setup_busy(setup_busy)
    );

    typedef struct packed {
        logic        occ;
        logic [23:0] pix;
        logic [10:0] x;
        logic [9:0]  y;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic vld_in = 1'b0;
    logic [3:0] vld_pipe = 4'd0;

    // Marks which output cycles carry a queued pixel (fixed 4-clock latency)
    always @(posedge clock) vld_pipe <= {vld_pipe[2:0], vld_in};

    always @(negedge clock) begin
        if (vld_pipe[3]) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow got occ=%0b with no expected entry", occupied);
            end else begin
                mon_e = exp_q.pop_front();
                if (occupied !== mon_e.occ || pixel !== mon_e.pix) begin
                    errors++;
                    $display("FAIL pix(%0d,%0d) got occ=%0b pixel=%06h expected occ=%0b pixel=%06h",
                             mon_e.x, mon_e.y, occupied, pixel, mon_e.occ, mon_e.pix);
                end else begin
                    $display("ok   pix(%0d,%0d) occ=%0b pixel=%06h", mon_e.x, mon_e.y, occupied, pixel);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, expv);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic push_pix(input int x, input int y, input bit occ);
        exp_t e;
        e.occ = occ;
        e.pix = occ ? COLOR : 24'd0;
        e.x   = 11'(x);
        e.y   = 10'(y);
        exp_q.push_back(e);
        hcount = 11'(x);
        vcount = 10'(y);
        vld_in = 1'b1;
        @(posedge clock); #1;
    endtask

    // Each probe is followed by an off-blade filler so a latency error shows up
    task automatic pix(input int x, input int y, input bit occ);
        push_pix(x, y, occ);
        push_pix(1000, 700, 1'b0);
        vld_in = 1'b0;
    endtask

    task automatic set_handles(input int tx, input int ty, input int tz,
                               input int bx, input int by, input int bz);
        handle_top_x    = 11'(tx);
        handle_top_y    = 10'(ty);
        handle_top_z    = 11'(tz);
        handle_bottom_x = 11'(bx);
        handle_bottom_y = 10'(by);
        handle_bottom_z = 11'(bz);
    endtask

    task automatic frame();
        frame_start = 1'b1;
        @(posedge clock); #1;
        frame_start = 1'b0;
        for (int i = 0; i < 20 && setup_busy; i++) begin
            @(posedge clock); #1;
        end
        check("frame_done_busy", 32'(setup_busy), 32'd0);
    endtask

    initial begin
        int busy_cnt;

        #12;
        check("reset_occupied", 32'(occupied), 32'd0);
        check("reset_pixel", 32'(pixel), 32'd0);
        check("reset_busy", 32'(setup_busy), 32'd0);
        #10;
        reset_n = 1'b1;
        @(posedge clock); #1;

        // No frame yet: nothing drawn
        set_handles(400, 300, 0, 400, 340, 0);
        enable = 1'b1;
        pix(400, 280, 0);
        pix(400, 300, 0);

        // Reset in the middle of setup
        frame_start = 1'b1;
        @(posedge clock); #1;
        frame_start = 1'b0;
        @(posedge clock); #1;
        check("busy_before_midreset", 32'(setup_busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("busy_async_reset", 32'(setup_busy), 32'd0);
        @(posedge clock); #3;
        reset_n = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("busy_after_reset", 32'(setup_busy), 32'd0);
        pix(400, 280, 0);

        // Ignition frame 1: ign=2, v=(0,-5), tip at y=295
        frame();
        pix(400, 295, 1);
        pix(400, 294, 0);
        pix(400, 300, 1);

        // Frame 2 with a second pulse during S_EXT, which must be ignored
        frame_start = 1'b1;
        @(posedge clock); #1;
        frame_start = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (setup_busy) busy_cnt++;
            frame_start = (i == 1);
            @(posedge clock); #1;
        end
        frame_start = 1'b0;
        check("busy_cycles", 32'(busy_cnt), 32'd4);
        pix(400, 290, 1);
        pix(400, 289, 0);

        // Frames 3..8 reach ign=16, frame 9 must saturate
        for (int f = 3; f <= 9; f++) frame();
        pix(400, 280, 1);
        pix(400, 260, 1);
        pix(400, 259, 0);
        pix(400, 301, 0);
        pix(407, 280, 0);
        pix(406, 280, 1);
        pix(394, 280, 1);
        pix(393, 280, 0);

        // New handle inputs without a frame leave the active blade untouched
        set_handles(300, 200, 0, 340, 200, 0);
        pix(400, 280, 1);
        pix(270, 200, 0);

        frame();
        pix(270, 200, 1);
        pix(270, 206, 1);
        pix(270, 207, 0);
        pix(270, 194, 1);
        pix(301, 200, 0);
        pix(260, 200, 1);
        pix(259, 200, 0);

        // Depth z=256 narrows the half-width to 2
        set_handles(400, 300, 256, 400, 340, 256);
        frame();
        pix(402, 280, 1);
        pix(403, 280, 0);
        pix(398, 280, 1);
        pix(397, 280, 0);

        // Retraction: 7 frames leave ign=2, the 8th reaches 0, the 9th must not wrap
        enable = 1'b0;
        for (int f = 1; f <= 7; f++) frame();
        pix(400, 295, 1);
        pix(400, 294, 0);
        frame();
        pix(400, 300, 0);
        pix(400, 299, 0);
        frame();
        pix(400, 290, 0);
        pix(400, 280, 0);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            @(posedge clock); #1;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
